miller_rx_ctrl: RTL and testbench

MILLER_RX_CTRL -- requirements
Module: miller_rx_ctrl

---
 rtl/miller_rx_ctrl_if.sv | 31 +++
 rtl/miller_rx_ctrl.sv | 168 ++++++++++++++++
 tb/tb_miller_rx_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/miller_rx_ctrl_if.sv
// Signal bundle between the Miller receive controller and its neighbours.
// The slave modport is the controller side. The master modport is the side that
// drives the detector pulses and consumes the assembled bytes and frame status.
interface miller_rx_ctrl_if;
    logic       in_enable;
    logic       in_sof_detected;
    logic       in_bit_valid;
    logic       in_bit;
    logic       in_eof_detected;
    logic       out_sof_en;
    logic       out_eof_en;
    logic [7:0] out_data;
    logic       out_data_valid;
    logic       out_parity_err;
    logic       out_frame_done;
    logic       out_frame_err;
    logic       out_short_frame;
    logic [5:0] out_byte_cnt;

    modport slave (
        input  in_enable, in_sof_detected, in_bit_valid, in_bit, in_eof_detected,
        output out_sof_en, out_eof_en, out_data, out_data_valid, out_parity_err,
               out_frame_done, out_frame_err, out_short_frame, out_byte_cnt
    );

    modport master (
        output in_enable, in_sof_detected, in_bit_valid, in_bit, in_eof_detected,
        input  out_sof_en, out_eof_en, out_data, out_data_valid, out_parity_err,
               out_frame_done, out_frame_err, out_short_frame, out_byte_cnt
    );
endinterface

// File: rtl/miller_rx_ctrl.sv
// Miller receive frame controller. It hunts for a start of frame and then
// assembles decoded bits into odd-parity bytes, sent LSB first. It recognises
// the 7-bit short frame and ends a frame on EoF or on an ETU silence timeout.
// All outputs are registered.
module miller_rx_ctrl #(
    parameter int ETU_CLKS    = 32,
    parameter int TIMEOUT_ETU = 4
) (
    input  logic            in_clk,
    input  logic            in_PoR,
    miller_rx_ctrl_if.slave bus
);
    localparam int TIMEOUT_CLKS = TIMEOUT_ETU * ETU_CLKS;
    localparam int TMR_W        = $clog2(TIMEOUT_CLKS + 1);
    // The timer is checked before it increments. Matching on the last count
    // makes the abort happen exactly TIMEOUT_CLKS cycles after the last strobe.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {IDLE, HUNT, RX, DONE, ERR} state_t;

    state_t           state_reg, state_next;
    logic [3:0]       bit_cnt_reg, bit_cnt_next;
    logic [8:0]       shift_reg, shift_next;
    logic [TMR_W-1:0] timer_reg, timer_next;
    logic [7:0]       data_reg, data_next;
    logic             data_valid_reg, data_valid_next;
    logic             parity_err_reg, parity_err_next;
    logic             frame_done_reg, frame_done_next;
    logic             frame_err_reg, frame_err_next;
    logic             short_reg, short_next;
    logic [5:0]       byte_cnt_reg, byte_cnt_next;
    logic             sof_en_reg, sof_en_next;
    logic             eof_en_reg, eof_en_next;

    // State register
    always_ff @(posedge in_clk or posedge in_PoR) begin
        if (in_PoR) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge in_clk or posedge in_PoR) begin
        if (in_PoR) begin
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            timer_reg      <= '0;
            data_reg       <= '0;
            data_valid_reg <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            short_reg      <= 1'b0;
            byte_cnt_reg   <= '0;
            sof_en_reg     <= 1'b0;
            eof_en_reg     <= 1'b0;
        end else begin
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            timer_reg      <= timer_next;
            data_reg       <= data_next;
            data_valid_reg <= data_valid_next;
            parity_err_reg <= parity_err_next;
            frame_done_reg <= frame_done_next;
            frame_err_reg  <= frame_err_next;
            short_reg      <= short_next;
            byte_cnt_reg   <= byte_cnt_next;
            sof_en_reg     <= sof_en_next;
            eof_en_reg     <= eof_en_next;
        end
    end

    // Next-state, bit assembly, frame-end decisions and output pulses
    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        timer_next      = timer_reg;
        data_next       = data_reg;
        data_valid_next = 1'b0;
        parity_err_next = 1'b0;
        frame_done_next = 1'b0;
        frame_err_next  = 1'b0;
        short_next      = short_reg;
        byte_cnt_next   = byte_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (bus.in_enable) begin
                    state_next = HUNT;
                end
            end
            HUNT: begin
                if (bus.in_sof_detected) begin
                    state_next    = RX;
                    bit_cnt_next  = '0;
                    shift_next    = '0;
                    byte_cnt_next = '0;
                    short_next    = 1'b0;
                    timer_next    = '0;
                end
            end
            RX: begin
                // EoF takes priority, so a strobe in the same cycle is dropped.
                if (bus.in_eof_detected) begin
                    if (bit_cnt_reg == 4'd7 && byte_cnt_reg == 6'd0) begin
                        state_next      = DONE;
                        frame_done_next = 1'b1;
                        data_next       = {1'b0, shift_reg[6:0]};
                        data_valid_next = 1'b1;
                        short_next      = 1'b1;
                    end else if (bit_cnt_reg == 4'd0 && byte_cnt_reg != 6'd0) begin
                        state_next      = DONE;
                        frame_done_next = 1'b1;
                    end else begin
                        state_next     = ERR;
                        frame_err_next = 1'b1;
                    end
                end else if (bus.in_bit_valid) begin
                    timer_next = '0;
                    if (bit_cnt_reg == 4'd8) begin
                        // The ninth bit is the odd-parity bit. An even total is an error.
                        bit_cnt_next    = '0;
                        data_next       = shift_reg[7:0];
                        data_valid_next = 1'b1;
                        parity_err_next = ~(^{bus.in_bit, shift_reg[7:0]});
                        if (byte_cnt_reg != 6'd63) begin
                            byte_cnt_next = byte_cnt_reg + 6'd1;
                        end
                    end else begin
                        shift_next[bit_cnt_reg] = bus.in_bit;
                        bit_cnt_next            = bit_cnt_reg + 4'd1;
                    end
                end else if (timer_reg == TMR_LAST) begin
                    state_next     = ERR;
                    frame_err_next = 1'b1;
                end else begin
                    timer_next = timer_reg + TMR_W'(1);
                end
            end
            DONE:    state_next = HUNT;
            ERR:     state_next = HUNT;
            default: state_next = IDLE;
        endcase

        // Dropping enable wins over everything and ends the frame silently.
        if (!bus.in_enable) begin
            state_next      = IDLE;
            frame_done_next = 1'b0;
            frame_err_next  = 1'b0;
        end

        sof_en_next = (state_next == HUNT);
        eof_en_next = (state_next == RX);
    end

    assign bus.out_sof_en      = sof_en_reg;
    assign bus.out_eof_en      = eof_en_reg;
    assign bus.out_data        = data_reg;
    assign bus.out_data_valid  = data_valid_reg;
    assign bus.out_parity_err  = parity_err_reg;
    assign bus.out_frame_done  = frame_done_reg;
    assign bus.out_frame_err   = frame_err_reg;
    assign bus.out_short_frame = short_reg;
    assign bus.out_byte_cnt    = byte_cnt_reg;
endmodule

// File: tb/tb_miller_rx_ctrl.sv
// Self-checking bench for miller_rx_ctrl. Each frame is described as a list of
// bytes plus a partial-bit tail and an end mode. The expected bytes, parity
// flags and frame outcome are derived from that list. A negedge monitor gathers
// what the DUT actually emitted.
module tb_miller_rx_ctrl;
    localparam int TIMEOUT_CLKS = 4 * 32;

    logic clk = 1'b0;
    logic por;
    always #5 clk = ~clk;

    miller_rx_ctrl_if bus ();

    miller_rx_ctrl #(.ETU_CLKS(32), .TIMEOUT_ETU(4)) dut (
        .in_clk (clk),
        .in_PoR (por),
        .bus    (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: byte strobes as {parity_err, data}; pulse cycles are counted
    logic [8:0] got_q[$];
    int done_cnt = 0;
    int err_cnt  = 0;
    always @(negedge clk) begin
        if (bus.out_data_valid === 1'b1) got_q.push_back({bus.out_parity_err, bus.out_data});
        if (bus.out_frame_done === 1'b1) done_cnt++;
        if (bus.out_frame_err === 1'b1)  err_cnt++;
    end

    // Frame description: bytes as {parity_bit, data}, partial tail, end mode
    // (0 = EoF alone, 1 = EoF together with one more strobe, 2 = go silent)
    logic [8:0] fr_bytes[$];
    int         fr_partial;
    logic [7:0] fr_pbits;
    int         fr_mode;
    int         fr_gap_max;

    task automatic send_bit(input logic b, input int gap);
        bus.in_bit       = b;
        bus.in_bit_valid = 1'b1;
        @(negedge clk);
        bus.in_bit_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic run_frame(input string name);
        logic [8:0] exp_q[$];
        logic       bits_q[$];
        logic       exp_short;
        int         exp_done, exp_cnt, nb, j, n;
        nb = fr_bytes.size();
        // Reference outcome, taken from the frame description
        for (int i = 0; i < nb; i++)
            exp_q.push_back({($countones(fr_bytes[i]) % 2 == 0) ? 1'b1 : 1'b0, fr_bytes[i][7:0]});
        exp_short = (nb == 0 && fr_partial == 7 && fr_mode != 2);
        if (exp_short) begin
            exp_q.push_back({2'b00, fr_pbits[6:0]});
            exp_done = 1;
        end else begin
            exp_done = (fr_mode != 2 && fr_partial == 0 && nb >= 1) ? 1 : 0;
        end
        exp_cnt = exp_short ? 0 : ((nb > 63) ? 63 : nb);
        for (int i = 0; i < nb; i++)
            for (int k = 0; k < 9; k++) bits_q.push_back(fr_bytes[i][k]);
        for (int k = 0; k < fr_partial; k++) bits_q.push_back(fr_pbits[k]);

        // Drive the frame
        got_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
        check({name, ".sof_en_hunt"}, bus.out_sof_en, 1);
        bus.in_sof_detected = 1'b1;
        @(negedge clk);
        bus.in_sof_detected = 1'b0;
        check({name, ".eof_en_rx"}, {bus.out_sof_en, bus.out_eof_en}, 2'b01);
        n = bits_q.size();
        for (int i = 0; i < n; i++)
            send_bit(bits_q[i], (fr_mode == 2 && i == n - 1) ? 0 : $urandom_range(0, fr_gap_max));
        if (fr_mode == 2) begin
            j = 0;
            while (j < TIMEOUT_CLKS + 20 && bus.out_frame_err !== 1'b1) begin
                @(negedge clk);
                j++;
            end
            check({name, ".timeout_cycles"}, j, TIMEOUT_CLKS);
            repeat (4) @(negedge clk);
        end else begin
            bus.in_eof_detected = 1'b1;
            if (fr_mode == 1) begin
                bus.in_bit_valid = 1'b1;
                bus.in_bit       = 1'($urandom);
            end
            @(negedge clk);
            bus.in_eof_detected = 1'b0;
            bus.in_bit_valid    = 1'b0;
            repeat (8) @(negedge clk);
        end

        // Compare against the reference
        check({name, ".n_bytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s.byte%0d", name, i), got_q[i], exp_q[i]);
        if (exp_q.size() > 0) check({name, ".data_hold"}, bus.out_data, exp_q[exp_q.size() - 1][7:0]);
        check({name, ".done_cnt"}, done_cnt, exp_done);
        check({name, ".err_cnt"}, err_cnt, 1 - exp_done);
        check({name, ".short"}, bus.out_short_frame, exp_short);
        check({name, ".byte_cnt"}, bus.out_byte_cnt, exp_cnt);
        check({name, ".back_in_hunt"}, {bus.out_sof_en, bus.out_eof_en}, 2'b10);
        $display("[TB] frame %s: bytes=%0d partial=%0d mode=%0d strobes=%0d done=%0d err=%0d cnt=%0d",
                 name, nb, fr_partial, fr_mode, got_q.size(), done_cnt, err_cnt, bus.out_byte_cnt);
    endtask

    task automatic set_frame(input int partial, input logic [7:0] pbits, input int mode);
        fr_partial = partial;
        fr_pbits   = pbits;
        fr_mode    = mode;
        fr_gap_max = 3;
    endtask

    task automatic gen_random();
        logic [7:0] d;
        logic       p;
        int         nb;
        fr_bytes.delete();
        if ($urandom_range(0, 4) == 0) begin
            nb         = 0;
            fr_partial = 7;
        end else begin
            nb         = $urandom_range(0, 3);
            fr_partial = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 8);
        end
        for (int i = 0; i < nb; i++) begin
            d = 8'($urandom);
            p = ($urandom_range(0, 3) == 0) ? ^d : ~^d;
            fr_bytes.push_back({p, d});
        end
        fr_pbits   = 8'($urandom);
        fr_mode    = ($urandom_range(0, 7) == 0) ? 2 : (($urandom_range(0, 3) == 0) ? 1 : 0);
        fr_gap_max = $urandom_range(0, 5);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        por                 = 1'b1;
        bus.in_enable       = 1'b0;
        bus.in_sof_detected = 1'b0;
        bus.in_bit_valid    = 1'b0;
        bus.in_bit          = 1'b0;
        bus.in_eof_detected = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.outputs", {bus.out_sof_en, bus.out_eof_en, bus.out_data, bus.out_data_valid,
              bus.out_parity_err, bus.out_frame_done, bus.out_frame_err, bus.out_short_frame,
              bus.out_byte_cnt}, 0);
        bus.in_enable = 1'b1;
        por           = 1'b0;
        #1 check("reset.release_idle", bus.out_sof_en, 0);
        @(negedge clk);
        check("reset.hunt_after_one", bus.out_sof_en, 1);

        // Good one-byte frame
        fr_bytes = '{9'h1A5};
        set_frame(0, 8'h00, 0);
        run_frame("a5");
        // REQA short frame
        fr_bytes.delete();
        set_frame(7, 8'h26, 0);
        run_frame("reqa");
        // Two bytes, first with bad parity
        fr_bytes = '{9'h093, 9'h020};
        set_frame(0, 8'h00, 0);
        run_frame("93_20");
        // Four bits then silence
        fr_bytes.delete();
        set_frame(4, 8'h0B, 2);
        run_frame("timeout");
        // Twelve bits, EoF together with the thirteenth strobe
        fr_bytes = '{9'h13C};
        set_frame(3, 8'h05, 1);
        run_frame("eof_coinc");

        // Reset in the middle of a byte, then a clean frame
        got_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
        bus.in_sof_detected = 1'b1;
        @(negedge clk);
        bus.in_sof_detected = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1);
        por = 1'b1;
        #1 check("por.async_clear", {bus.out_sof_en, bus.out_eof_en, bus.out_data, bus.out_byte_cnt}, 0);
        repeat (3) @(negedge clk);
        por = 1'b0;
        repeat (3) @(negedge clk);
        check("por.no_stale", got_q.size() + done_cnt + err_cnt, 0);
        $display("[TB] por mid-byte: stale events=%0d", got_q.size() + done_cnt + err_cnt);
        fr_bytes = '{9'h1A5};
        set_frame(0, 8'h00, 0);
        run_frame("after_por");

        // Enable dropped mid-frame: silent return to IDLE, then HUNT again
        done_cnt = 0;
        err_cnt  = 0;
        bus.in_sof_detected = 1'b1;
        @(negedge clk);
        bus.in_sof_detected = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), 0);
        bus.in_enable = 1'b0;
        @(negedge clk);
        check("disable.idle", {bus.out_sof_en, bus.out_eof_en}, 2'b00);
        repeat (4) @(negedge clk);
        check("disable.no_pulse", done_cnt + err_cnt, 0);
        bus.in_enable = 1'b1;
        repeat (2) @(negedge clk);
        check("disable.rehunt", bus.out_sof_en, 1);
        $display("[TB] enable drop: pulses=%0d sof_en=%0b", done_cnt + err_cnt, bus.out_sof_en);

        // Byte counter saturation with back-to-back strobes
        fr_bytes.delete();
        for (int i = 0; i < 64; i++) fr_bytes.push_back({1'b1, 8'(i)});
        set_frame(0, 8'h00, 0);
        fr_gap_max = 0;
        run_frame("saturate");

        for (int f = 0; f < 30; f++) begin
            gen_random();
            run_frame($sformatf("rnd%0d", f));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
